// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the multi-slot alarm bank:
//   - slot state encoding (2-bit, legacy-compatible localparams)
//   - BCD validity checks for stored hour and minute values
//   - seconds-per-minute constant used to load the snooze counter
// ---------------------------------------------------------------------------
package alarm_pkg;

    typedef logic [1:0] slot_state_t;

    localparam slot_state_t ST_IDLE    = 2'd0;
    localparam slot_state_t ST_ARMED   = 2'd1;
    localparam slot_state_t ST_RINGING = 2'd2;
    localparam slot_state_t ST_SNOOZE  = 2'd3;

    localparam int unsigned SEC_PER_MIN = 60;

    // Hour must be a well-formed BCD value in 00..23.
    function automatic logic bcd_valid_hr(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd2) && (v <= 8'h23);
    endfunction

    // Minute must be a well-formed BCD value in 00..59.
    function automatic logic bcd_valid_min(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
    endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// ---------------------------------------------------------------------------
// alarm_bank_if
// Host-side programming bus of the alarm bank.
//   wr_en/wr_idx/wr_hr/wr_min/wr_on : one-cycle slot write strobe and data
//   stop/snooze                     : one-cycle user button pulses
//   rd_idx -> rd_hr/rd_min          : combinational readback of a slot
//   wr_err                          : one-cycle pulse when a write is rejected
// master = host / button logic, slave = alarm_bank.
// ---------------------------------------------------------------------------
interface alarm_bank_if;

    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_hr;
    logic [7:0] wr_min;
    logic       wr_on;
    logic       stop;
    logic       snooze;
    logic [2:0] rd_idx;
    logic [7:0] rd_hr;
    logic [7:0] rd_min;
    logic       wr_err;

    modport master (
        output wr_en, wr_idx, wr_hr, wr_min, wr_on, stop, snooze, rd_idx,
        input  rd_hr, rd_min, wr_err
    );

    modport slave (
        input  wr_en, wr_idx, wr_hr, wr_min, wr_on, stop, snooze, rd_idx,
        output rd_hr, rd_min, wr_err
    );

endinterface

// File: rtl/alarm_slot.sv
// ---------------------------------------------------------------------------
// alarm_slot
// One alarm slot: stored BCD hour/minute, 4-state FSM, ring and snooze
// counters. The top decides which slot a write targets and whether it is
// valid; the slot only sees an already-qualified wr_hit.
// Ports:
//   Clk, CR                 clock, synchronous active-high clear
//   tick_1hz                one-cycle pulse per second
//   Hour/Minute/Second      running BCD time
//   wr_hit                  accepted write targets this slot
//   wr_hr/wr_min/wr_on      write data
//   stop/snooze             button pulses (shared by all slots)
//   slot_state              registered FSM state
//   alarm_hr/alarm_min      stored alarm time
// Same-cycle priority: CR > write > stop > snooze > tick.
// ---------------------------------------------------------------------------
module alarm_slot
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic        Clk,
    input  logic        CR,
    input  logic        tick_1hz,
    input  logic [7:0]  Hour,
    input  logic [7:0]  Minute,
    input  logic [7:0]  Second,
    input  logic        wr_hit,
    input  logic [7:0]  wr_hr,
    input  logic [7:0]  wr_min,
    input  logic        wr_on,
    input  logic        stop,
    input  logic        snooze,
    output slot_state_t slot_state,
    output logic [7:0]  alarm_hr,
    output logic [7:0]  alarm_min
);

    localparam logic [7:0]  RING_LAST = 8'(RING_SEC - 1);
    localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * SEC_PER_MIN);

    slot_state_t state_r;
    logic [7:0]  hr_r;
    logic [7:0]  min_r;
    logic [7:0]  ring_cnt_r;
    logic [11:0] snz_cnt_r;
    logic        match_s;

    // Raw BCD equality; the alarm fires only at the top of the minute.
    assign match_s = (Hour == hr_r) && (Minute == min_r) && (Second == 8'h00);

    // Slot FSM, stored time and ring/snooze counters.
    always_ff @(posedge Clk) begin
        if (CR) begin
            state_r    <= ST_IDLE;
            hr_r       <= 8'h00;
            min_r      <= 8'h00;
            ring_cnt_r <= 8'd0;
            snz_cnt_r  <= 12'd0;
        end else if (wr_hit) begin
            // A write reprograms the slot and cancels any ring or snooze.
            hr_r       <= wr_hr;
            min_r      <= wr_min;
            state_r    <= wr_on ? ST_ARMED : ST_IDLE;
            ring_cnt_r <= 8'd0;
            snz_cnt_r  <= 12'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_ARMED: begin
                    if (tick_1hz && match_s) begin
                        state_r    <= ST_RINGING;
                        ring_cnt_r <= 8'd0;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_RINGING: begin
                    if (stop) begin
                        state_r <= ST_ARMED;
                    end else if (snooze) begin
                        state_r   <= ST_SNOOZE;
                        snz_cnt_r <= SNZ_LOAD;
                    end else if (tick_1hz) begin
                        // The match tick counts as second 0, so RING_SEC
                        // further ticks end the ring.
                        if (ring_cnt_r == RING_LAST) begin
                            state_r <= ST_ARMED;
                        end else begin
                            ring_cnt_r <= ring_cnt_r + 8'd1;
                        end
                    end else begin
                        state_r <= ST_RINGING;
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        state_r <= ST_ARMED;
                    end else if (tick_1hz) begin
                        if (snz_cnt_r == 12'd1) begin
                            state_r    <= ST_RINGING;
                            ring_cnt_r <= 8'd0;
                        end else begin
                            snz_cnt_r <= snz_cnt_r - 12'd1;
                        end
                    end else begin
                        state_r <= ST_SNOOZE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign slot_state = state_r;
    assign alarm_hr   = hr_r;
    assign alarm_min  = min_r;

endmodule

// File: rtl/alarm_bank.sv
// ---------------------------------------------------------------------------
// alarm_bank
// Multi-slot alarm clock that sits beside top_clock. N_ALARM independent
// alarm_slot instances compare their stored BCD time with the running time.
// The top holds write decode and validation, readback mux, registered status
// (ringing/snoozed/ring_any/active_idx), the lowest-index priority encoder
// and the gated buzzer tone.
// Ports:
//   Clk, CR              clock (50 MHz), synchronous active-high clear
//   tick_1hz             one-cycle pulse per second, aligned to Second update
//   Hour/Minute/Second   running BCD time
//   bus                  programming/readback bus (alarm_bank_if.slave)
//   ringing/snoozed      per-slot registered status
//   ring_any             OR of ringing
//   active_idx           lowest ringing slot, 0 when none
//   ALARM                registered buzzer tone
// ---------------------------------------------------------------------------
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARM    = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int TONE_DIV   = 25000
) (
    input  logic               Clk,
    input  logic               CR,
    input  logic               tick_1hz,
    input  logic [7:0]         Hour,
    input  logic [7:0]         Minute,
    input  logic [7:0]         Second,
    alarm_bank_if.slave        bus,
    output logic [N_ALARM-1:0] ringing,
    output logic [N_ALARM-1:0] snoozed,
    output logic               ring_any,
    output logic [2:0]         active_idx,
    output logic               ALARM
);

    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    slot_state_t        state_s [N_ALARM];
    logic [7:0]         hr_s    [N_ALARM];
    logic [7:0]         min_s   [N_ALARM];

    logic               wr_ok_s;
    logic [N_ALARM-1:0] ring_now_s;
    logic [N_ALARM-1:0] snz_now_s;
    logic [2:0]         active_now_s;
    logic [7:0]         rd_hr_s;
    logic [7:0]         rd_min_s;

    logic [N_ALARM-1:0] ringing_r;
    logic [N_ALARM-1:0] snoozed_r;
    logic               ring_any_r;
    logic [2:0]         active_idx_r;
    logic               wr_err_r;
    logic [TW-1:0]      tone_cnt_r;
    logic               tone_sq_r;
    logic               beat_r;
    logic               alarm_r;

    // A write is accepted only with an in-range slot and well-formed BCD.
    assign wr_ok_s = bus.wr_en
                   && (32'(bus.wr_idx) < N_ALARM)
                   && bcd_valid_hr(bus.wr_hr)
                   && bcd_valid_min(bus.wr_min);

    for (genvar k = 0; k < N_ALARM; k++) begin : g_slot
        alarm_slot #(
            .RING_SEC   (RING_SEC),
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_slot (
            .Clk        (Clk),
            .CR         (CR),
            .tick_1hz   (tick_1hz),
            .Hour       (Hour),
            .Minute     (Minute),
            .Second     (Second),
            .wr_hit     (wr_ok_s && (bus.wr_idx == 3'(k))),
            .wr_hr      (bus.wr_hr),
            .wr_min     (bus.wr_min),
            .wr_on      (bus.wr_on),
            .stop       (bus.stop),
            .snooze     (bus.snooze),
            .slot_state (state_s[k]),
            .alarm_hr   (hr_s[k]),
            .alarm_min  (min_s[k])
        );

        assign ring_now_s[k] = (state_s[k] == ST_RINGING);
        assign snz_now_s[k]  = (state_s[k] == ST_SNOOZE);
    end

    // Lowest ringing index wins; scanning downwards leaves the lowest last.
    always_comb begin
        active_now_s = 3'd0;
        for (int k = N_ALARM - 1; k >= 0; k--) begin
            if (ring_now_s[k]) begin
                active_now_s = 3'(k);
            end else begin
            end
        end
    end

    // Readback mux; out-of-range indices read as 00:00.
    always_comb begin
        rd_hr_s  = 8'h00;
        rd_min_s = 8'h00;
        for (int k = 0; k < N_ALARM; k++) begin
            if (bus.rd_idx == 3'(k)) begin
                rd_hr_s  = hr_s[k];
                rd_min_s = min_s[k];
            end else begin
            end
        end
    end

    assign bus.rd_hr  = rd_hr_s;
    assign bus.rd_min = rd_min_s;

    // Registered status and write-error pulse.
    always_ff @(posedge Clk) begin
        if (CR) begin
            ringing_r    <= '0;
            snoozed_r    <= '0;
            ring_any_r   <= 1'b0;
            active_idx_r <= 3'd0;
            wr_err_r     <= 1'b0;
        end else begin
            ringing_r    <= ring_now_s;
            snoozed_r    <= snz_now_s;
            ring_any_r   <= |ring_now_s;
            active_idx_r <= active_now_s;
            wr_err_r     <= bus.wr_en && !wr_ok_s;
        end
    end

    // Free-running tone divider producing the square wave.
    always_ff @(posedge Clk) begin
        if (CR) begin
            tone_cnt_r <= '0;
            tone_sq_r  <= 1'b0;
        end else if (tone_cnt_r == TONE_LAST) begin
            tone_cnt_r <= '0;
            tone_sq_r  <= ~tone_sq_r;
        end else begin
            tone_cnt_r <= tone_cnt_r + TW'(1);
        end
    end

    // Once-per-second on/off beat; restarts silent each time ringing begins.
    always_ff @(posedge Clk) begin
        if (CR) begin
            beat_r <= 1'b0;
        end else if (!ring_any_r) begin
            beat_r <= 1'b0;
        end else if (tick_1hz) begin
            beat_r <= ~beat_r;
        end else begin
            beat_r <= beat_r;
        end
    end

    // Gated, registered buzzer output.
    always_ff @(posedge Clk) begin
        if (CR) begin
            alarm_r <= 1'b0;
        end else begin
            alarm_r <= ring_any_r && tone_sq_r && beat_r;
        end
    end

    assign bus.wr_err = wr_err_r;
    assign ringing    = ringing_r;
    assign snoozed    = snoozed_r;
    assign ring_any   = ring_any_r;
    assign active_idx = active_idx_r;
    assign ALARM      = alarm_r;

endmodule

// File: tb/tb_alarm_bank.sv
// ---------------------------------------------------------------------------
// tb_alarm_bank
// Directed bench for alarm_bank. Expected values are queued when a step is
// driven and popped when the corresponding DUT output is sampled.
// TONE_DIV is shrunk to 4 so a tone period is 8 clocks.
// ---------------------------------------------------------------------------
module tb_alarm_bank;

    localparam int N_ALARM    = 4;
    localparam int RING_SEC   = 60;
    localparam int SNOOZE_MIN = 5;
    localparam int TONE_DIV   = 4;

    logic               Clk;
    logic               CR;
    logic               tick_1hz;
    logic [7:0]         Hour;
    logic [7:0]         Minute;
    logic [7:0]         Second;
    logic [N_ALARM-1:0] ringing;
    logic [N_ALARM-1:0] snoozed;
    logic               ring_any;
    logic [2:0]         active_idx;
    logic               ALARM;

    alarm_bank_if bus_if ();

    alarm_bank #(
        .N_ALARM    (N_ALARM),
        .RING_SEC   (RING_SEC),
        .SNOOZE_MIN (SNOOZE_MIN),
        .TONE_DIV   (TONE_DIV)
    ) dut (
        .Clk        (Clk),
        .CR         (CR),
        .tick_1hz   (tick_1hz),
        .Hour       (Hour),
        .Minute     (Minute),
        .Second     (Second),
        .bus        (bus_if.slave),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .ring_any   (ring_any),
        .active_idx (active_idx),
        .ALARM      (ALARM)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tod     = 0;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %0h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic drive_time();
        Hour   = to_bcd(tod / 3600);
        Minute = to_bcd((tod / 60) % 60);
        Second = to_bcd(tod % 60);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        tod = h * 3600 + m * 60 + s;
        drive_time();
    endtask

    // One second passes: new time with its tick, then a few settle clocks.
    task automatic advance();
        tod = (tod + 1) % 86400;
        drive_time();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic wr(input logic [2:0] idx, input logic [7:0] h,
                      input logic [7:0] m, input logic on);
        bus_if.wr_idx = idx;
        bus_if.wr_hr  = h;
        bus_if.wr_min = m;
        bus_if.wr_on  = on;
        bus_if.wr_en  = 1'b1;
        cyc();
        bus_if.wr_en  = 1'b0;
    endtask

    task automatic buttons(input logic st, input logic sn);
        bus_if.stop   = st;
        bus_if.snooze = sn;
        cyc();
        bus_if.stop   = 1'b0;
        bus_if.snooze = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic count_rises(output int r);
        logic prev;
        prev = ALARM;
        r = 0;
        repeat (16) begin
            cyc();
            if (!prev && ALARM) r++;
            prev = ALARM;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;

        CR            = 1'b1;
        tick_1hz      = 1'b0;
        Hour          = 8'h00;
        Minute        = 8'h00;
        Second        = 8'h00;
        bus_if.wr_en  = 1'b0;
        bus_if.wr_idx = 3'd0;
        bus_if.wr_hr  = 8'h00;
        bus_if.wr_min = 8'h00;
        bus_if.wr_on  = 1'b0;
        bus_if.stop   = 1'b0;
        bus_if.snooze = 1'b0;
        bus_if.rd_idx = 3'd0;
        repeat (2) cyc();
        CR = 1'b0;
        cyc();

        // Reset state
        expect_v("rst_ringing", 32'h0);  check_v(ringing);
        expect_v("rst_snoozed", 32'h0);  check_v(snoozed);
        expect_v("rst_ring_any", 32'h0); check_v(ring_any);
        expect_v("rst_active", 32'h0);   check_v(active_idx);
        expect_v("rst_alarm", 32'h0);    check_v(ALARM);
        expect_v("rst_wr_err", 32'h0);   check_v(bus_if.wr_err);
        expect_v("rst_rd_hr", 32'h0);    check_v(bus_if.rd_hr);

        // 1. Slot0 07:30 rings at the minute, tone only in beat-high seconds
        wr(3'd0, 8'h07, 8'h30, 1'b1);
        expect_v("wr0_err", 32'h0);      check_v(bus_if.wr_err);
        expect_v("wr0_rd_hr", 32'h07);   check_v(bus_if.rd_hr);
        expect_v("wr0_rd_min", 32'h30);  check_v(bus_if.rd_min);
        set_time(7, 29, 58);
        advance();
        expect_v("pre_match", 32'h0);    check_v(ringing);
        advance();
        expect_v("match_ring", 32'h1);   check_v(ringing);
        expect_v("match_any", 32'h1);    check_v(ring_any);
        expect_v("match_active", 32'h0); check_v(active_idx);
        expect_v("match_snz", 32'h0);    check_v(snoozed);
        count_rises(rises);
        expect_v("beat0_rises", 32'd0);  check_v(rises);
        advance();
        count_rises(rises);
        expect_v("beat1_rises", 32'd2);  check_v(rises);
        advance();
        count_rises(rises);
        expect_v("beat2_rises", 32'd0);  check_v(rises);

        // 2. Ring timeout after RING_SEC ticks, then rings again next day
        for (int i = 0; i < 57; i++) advance();
        expect_v("tick59_ring", 32'h1);  check_v(ringing);
        advance();
        expect_v("tick60_ring", 32'h0);  check_v(ringing);
        expect_v("tick60_any", 32'h0);   check_v(ring_any);
        expect_v("tick60_alarm", 32'h0); check_v(ALARM);
        set_time(7, 29, 59);
        advance();
        expect_v("day2_ring", 32'h1);    check_v(ringing);

        // 3. Snooze for SNOOZE_MIN minutes, then stop
        buttons(1'b0, 1'b1);
        expect_v("snz_flag", 32'h1);     check_v(snoozed);
        expect_v("snz_ring", 32'h0);     check_v(ringing);
        expect_v("snz_alarm", 32'h0);    check_v(ALARM);
        for (int i = 0; i < 299; i++) advance();
        expect_v("snz299_flag", 32'h1);  check_v(snoozed);
        advance();
        expect_v("snz300_ring", 32'h1);  check_v(ringing);
        expect_v("snz300_flag", 32'h0);  check_v(snoozed);
        buttons(1'b1, 1'b0);
        expect_v("stop_ring", 32'h0);    check_v(ringing);
        expect_v("stop_snz", 32'h0);     check_v(snoozed);

        // 4. Two slots at 06:00, priority encoder, stop beats snooze
        wr(3'd1, 8'h06, 8'h00, 1'b1);
        wr(3'd2, 8'h06, 8'h00, 1'b1);
        set_time(5, 59, 59);
        advance();
        expect_v("dual_ring", 32'h6);    check_v(ringing);
        expect_v("dual_active", 32'h1);  check_v(active_idx);
        buttons(1'b1, 1'b1);
        expect_v("ss_ring", 32'h0);      check_v(ringing);
        expect_v("ss_snz", 32'h0);       check_v(snoozed);
        set_time(5, 59, 59);
        advance();
        expect_v("dual2_ring", 32'h6);   check_v(ringing);
        wr(3'd2, 8'h06, 8'h00, 1'b1);
        repeat (2) cyc();
        expect_v("cancel_ring", 32'h2);  check_v(ringing);
        expect_v("cancel_act", 32'h1);   check_v(active_idx);
        buttons(1'b0, 1'b1);
        expect_v("snz1_flag", 32'h2);    check_v(snoozed);
        expect_v("snz1_ring", 32'h0);    check_v(ringing);

        // 5. Rejected writes pulse wr_err and leave the slot untouched
        wr(3'd1, 8'h24, 8'h00, 1'b1);
        expect_v("bad_hr_err", 32'h1);   check_v(bus_if.wr_err);
        cyc();
        expect_v("err_pulse", 32'h0);    check_v(bus_if.wr_err);
        wr(3'd1, 8'h06, 8'h5A, 1'b1);
        expect_v("bad_min_err", 32'h1);  check_v(bus_if.wr_err);
        wr(3'd4, 8'h06, 8'h00, 1'b1);
        expect_v("bad_idx_err", 32'h1);  check_v(bus_if.wr_err);
        wr(3'd1, 8'h1A, 8'h00, 1'b0);
        expect_v("bad_nib_err", 32'h1);  check_v(bus_if.wr_err);
        bus_if.rd_idx = 3'd1;
        #1;
        expect_v("keep_rd_hr", 32'h06);  check_v(bus_if.rd_hr);
        expect_v("keep_rd_min", 32'h00); check_v(bus_if.rd_min);
        expect_v("keep_snz", 32'h2);     check_v(snoozed);

        // 6. Slot3 rings while slot1 snoozes; CR clears everything
        wr(3'd3, 8'h06, 8'h01, 1'b1);
        expect_v("wr3_err", 32'h0);      check_v(bus_if.wr_err);
        for (int i = 0; i < 60; i++) advance();
        expect_v("mix_ring", 32'h8);     check_v(ringing);
        expect_v("mix_snz", 32'h2);      check_v(snoozed);
        expect_v("mix_active", 32'h3);   check_v(active_idx);
        CR = 1'b1;
        cyc();
        CR = 1'b0;
        bus_if.rd_idx = 3'd3;
        #1;
        expect_v("cr_ring", 32'h0);      check_v(ringing);
        expect_v("cr_snz", 32'h0);       check_v(snoozed);
        expect_v("cr_any", 32'h0);       check_v(ring_any);
        expect_v("cr_active", 32'h0);    check_v(active_idx);
        expect_v("cr_alarm", 32'h0);     check_v(ALARM);
        expect_v("cr_rd_hr", 32'h00);    check_v(bus_if.rd_hr);
        expect_v("cr_rd_min", 32'h00);   check_v(bus_if.rd_min);
        set_time(6, 0, 59);
        advance();
        expect_v("cr_noring", 32'h0);    check_v(ringing);
        expect_v("cr_nosnz", 32'h0);     check_v(snoozed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
